// File: rtl/mont_pkg.sv
// mont_pkg: shared state encoding and counter sizing for the Montgomery multiplier.
package mont_pkg;
    typedef enum logic [1:0] {IDLE, ITER, FINAL, ERR} state_t;
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/mont_step.sv
// mont_step: one radix-2 Montgomery iteration, acc <- (acc + ai*B + q*N) / 2.
module mont_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_acc,
    input  logic             i_ai,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH:0]   o_acc
);
    logic             w_q;
    logic [WIDTH+1:0] w_sum;
    assign w_q   = i_acc[0] ^ (i_ai & i_b[0]);
    // Full-width sum; q makes it even so the shift drops nothing
    assign w_sum = {1'b0, i_acc} + {2'b0, {WIDTH{i_ai}} & i_b} + {2'b0, {WIDTH{w_q}} & i_n};
    assign o_acc = (WIDTH+1)'(w_sum >> 1);
endmodule

// File: rtl/mont_mul_param.sv
// mont_mul_param: radix-2 Montgomery multiplier, Z = A*B*2^-WIDTH mod N, one bit per cycle.
module mont_mul_param
    import mont_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] z
);
    localparam int CNT_W = cnt_w(WIDTH);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_n, r_z;
    logic [WIDTH:0]   r_acc, w_acc_nx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done, r_err, w_last;

    assign w_last = r_cnt == CNT_W'(WIDTH - 1);

    mont_step #(.WIDTH(WIDTH)) u_step (
        .i_acc (r_acc),
        .i_ai  (r_a[0]),
        .i_b   (r_b),
        .i_n   (r_n),
        .o_acc (w_acc_nx)
    );

    always_ff @(posedge clk)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;

    always_comb
        w_next = r_state == IDLE ? (start ? (n[0] ? ITER : ERR) : IDLE) :
                 r_state == ITER ? (w_last ? FINAL : ITER) : IDLE;

    always_comb begin
        ready = r_state == IDLE;
        busy  = r_state != IDLE;
        done  = r_done;
        err   = r_err;
        z     = r_z;
    end

    // A is shifted out LSB first so the step always consumes bit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_z    <= '0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE && start) begin
                r_a   <= a;
                r_b   <= b;
                r_n   <= n;
                r_acc <= '0;
                r_cnt <= '0;
                r_err <= 1'b0;
            end else if (r_state == ITER) begin
                r_acc <= w_acc_nx;
                r_a   <= r_a >> 1;
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (r_state == FINAL) begin
                r_z    <= r_acc >= {1'b0, r_n} ? WIDTH'(r_acc - {1'b0, r_n}) : r_acc[WIDTH-1:0];
                r_done <= 1'b1;
            end else if (r_state == ERR) begin
                r_z    <= '0;
                r_err  <= 1'b1;
                r_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mont_mul_param.sv
// tb_mont_mul_param: vector table, corner sequences and random 32-bit checks against an arithmetic model.
module tb_mont_mul_param;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic s8 = 0, r8, bz8, d8, e8;
    logic [7:0] a8 = 0, b8 = 0, n8 = 0, z8;
    logic s32 = 0, r32, bz32, d32, e32;
    logic [31:0] a32 = 0, b32 = 0, n32 = 0, z32;

    mont_mul_param #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .n(n8),
        .ready(r8), .busy(bz8), .done(d8), .err(e8), .z(z8));
    mont_mul_param #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .start(s32), .a(a32), .b(b32), .n(n32),
        .ready(r32), .busy(bz32), .done(d32), .err(e32), .z(z32));

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A*B*2^-w mod N: reduce the product, then halve w times modulo N
    function automatic longint unsigned mref(input longint unsigned x, input longint unsigned y,
                                             input longint unsigned m, input int w);
        longint unsigned r = (x * y) % m;
        for (int i = 0; i < w; i++) r = r[0] ? (r + m) >> 1 : r >> 1;
        return r;
    endfunction

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] tn,
                        output logic [7:0] oz, output logic oe, output int lat);
        @(negedge clk); a8 = ta; b8 = tb_; n8 = tn; s8 = 1;
        @(posedge clk); #1 s8 = 0;
        lat = 999;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (d8) begin lat = c; break; end
        end
        oz = z8; oe = e8;
    endtask

    task automatic run32(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] tn,
                         output logic [31:0] oz, output int lat);
        @(negedge clk); a32 = ta; b32 = tb_; n32 = tn; s32 = 1;
        @(posedge clk); #1 s32 = 0;
        lat = 999;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            if (d32) begin lat = c; break; end
        end
        oz = z32;
    endtask

    typedef struct {logic [7:0] a, b, n, z; logic e; int lat;} vec_t;
    vec_t tbl[6];

    initial begin
        logic [7:0] oz8;
        logic [31:0] oz, ra, rb, rn;
        logic oe, saw;
        int lat;
        tbl[0] = '{8'd5,  8'd7,  8'd13, 8'd1, 1'b0, 9};
        tbl[1] = '{8'd1,  8'd1,  8'd13, 8'd3, 1'b0, 9};
        tbl[2] = '{8'd12, 8'd12, 8'd13, 8'd3, 1'b0, 9};
        tbl[3] = '{8'd0,  8'd9,  8'd13, 8'd0, 1'b0, 9};
        tbl[4] = '{8'd3,  8'd4,  8'd12, 8'd0, 1'b1, 1};
        tbl[5] = '{8'd5,  8'd7,  8'd13, 8'd1, 1'b0, 9};

        repeat (3) @(posedge clk); #1;
        chk("rst_ready8", 64'(r8), 1); chk("rst_busy8", 64'(bz8), 0); chk("rst_done8", 64'(d8), 0);
        chk("rst_err8", 64'(e8), 0); chk("rst_z8", 64'(z8), 0);
        chk("rst_ready32", 64'(r32), 1); chk("rst_z32", 64'(z32), 0);
        rst = 0;

        foreach (tbl[i]) begin
            run8(tbl[i].a, tbl[i].b, tbl[i].n, oz8, oe, lat);
            chk($sformatf("vec%0d_z", i), 64'(oz8), 64'(tbl[i].z));
            chk($sformatf("vec%0d_err", i), 64'(oe), 64'(tbl[i].e));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
        end
        repeat (4) @(posedge clk); #1;
        chk("hold_z", 64'(z8), 1); chk("hold_done", 64'(d8), 0); chk("hold_ready", 64'(r8), 1);

        // Back-to-back: each next start raised in the previous done cycle
        @(negedge clk); a8 = 1; b8 = 1; n8 = 13; s8 = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 s8 = 0;
            lat = 999;
            for (int c = 1; c <= 60; c++) begin
                @(posedge clk); #1;
                if (d8) begin lat = c; break; end
            end
            chk($sformatf("b2b%0d_lat", k), 64'(lat), 9);
            chk($sformatf("b2b%0d_z", k), 64'(z8), k == 0 ? 3 : k == 1 ? 3 : 0);
            chk($sformatf("b2b%0d_ready", k), 64'(r8), 1);
            if (k == 0) begin a8 = 12; b8 = 12; s8 = 1; end
            if (k == 1) begin a8 = 0; b8 = 9; s8 = 1; end
        end

        // Start pulse mid-operation must be ignored
        @(negedge clk); a8 = 5; b8 = 7; n8 = 13; s8 = 1;
        @(posedge clk); #1 s8 = 0;
        lat = 999;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            s8 = (c == 3);
            if (c == 3) begin a8 = 1; b8 = 1; n8 = 12; end
            if (d8) begin lat = c; break; end
        end
        s8 = 0;
        chk("ign_lat", 64'(lat), 9); chk("ign_z", 64'(z8), 1); chk("ign_err", 64'(e8), 0);

        // Reset mid-operation aborts without a done pulse
        @(negedge clk); a8 = 5; b8 = 7; n8 = 13; s8 = 1;
        @(posedge clk); #1 s8 = 0;
        saw = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 6) begin
                chk("arst_ready", 64'(r8), 1); chk("arst_busy", 64'(bz8), 0);
                chk("arst_z", 64'(z8), 0); chk("arst_done", 64'(d8), 0);
                rst = 0;
            end
            if (d8) saw = 1;
            if (c == 5) rst = 1;
        end
        chk("arst_nodone", 64'(saw), 0);
        run8(8'd1, 8'd1, 8'd13, oz8, oe, lat);
        chk("arst_fresh_z", 64'(oz8), 3); chk("arst_fresh_lat", 64'(lat), 9);

        for (int i = 0; i < 2000; i++) begin
            rn = (i < 2) ? 32'hFFFF_FFFF : ($urandom | 32'd1);
            ra = (i == 1) ? rn - 1 : 32'($urandom % rn);
            rb = (i == 1) ? rn - 1 : 32'($urandom % rn);
            run32(ra, rb, rn, oz, lat);
            chk($sformatf("rnd%0d_z a=%0h b=%0h n=%0h", i, ra, rb, rn), 64'(oz), mref(64'(ra), 64'(rb), 64'(rn), 32));
            if (i < 20) chk($sformatf("rnd%0d_lat", i), 64'(lat), 33);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
